// File: rtl/spi_master_cfg_if.sv
// spi_master_cfg_if: controller handshake, frame configuration and SPI pins of spi_master_cfg
interface spi_master_cfg_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W = 8,
  parameter int NUM_SS = 4,
  parameter int SS_W = 2
);
  logic start;
  logic [DATA_W-1:0] tx_data;
  logic [SS_W-1:0] ss_sel;
  logic cpol;
  logic cpha;
  logic lsb_first;
  logic [DIV_W-1:0] clk_div;
  logic MISO;
  logic MOSI;
  logic SCLK;
  logic [NUM_SS-1:0] SS_N;
  logic busy;
  logic done;
  logic [DATA_W-1:0] rx_data;
  logic rx_valid;
  modport master (
    input start, tx_data, ss_sel, cpol, cpha, lsb_first, clk_div, MISO,
    output MOSI, SCLK, SS_N, busy, done, rx_data, rx_valid
  );
  modport slave (
    output start, tx_data, ss_sel, cpol, cpha, lsb_first, clk_div, MISO,
    input MOSI, SCLK, SS_N, busy, done, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: SPI master with configurable width, divider, mode, bit order and slave select
module spi_master_cfg #(
  parameter int DATA_W = 8,
  parameter int DIV_W = 8,
  parameter int NUM_SS = 4,
  parameter int SS_W = 2
) (
  input logic clk,
  input logic rst,
  spi_master_cfg_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;
  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_W);
  localparam logic [EW-1:0] LAST_M1 = EW'(2 * DATA_W - 1);
  logic [1:0] state;
  logic [DIV_W-1:0] div_cnt, div_r;
  logic [EW-1:0] edge_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_data, tx_shift, rx_in;
  logic [NUM_SS-1:0] ss_n, ss_dec;
  logic cpha_r, lsb_r, sclk, mosi, busy, done;
  logic accept, tick, fire, leading, sample, shift_tx, tx_bit;
  assign accept = state == IDLE && bus.start && !done;
  assign tick = div_cnt == div_r;
  assign fire = tick && (state == SETUP || (state == XFER && edge_cnt != LAST));
  // edge_cnt holds edges already issued, so an even count means the next edge leads
  assign leading = !edge_cnt[0];
  assign sample = fire && (leading != cpha_r);
  assign shift_tx = fire && (cpha_r ? leading : !leading && edge_cnt != LAST_M1);
  assign tx_bit = lsb_r ? tx_sr[0] : tx_sr[DATA_W-1];
  assign tx_shift = lsb_r ? tx_sr >> 1 : tx_sr << 1;
  assign rx_in = lsb_r ? {bus.MISO, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], bus.MISO};
  always_comb begin
    ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++) ss_dec[i] = int'(bus.ss_sel) != i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div_cnt <= '0;
      div_r <= '0;
      edge_cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      rx_data <= '0;
      ss_n <= '1;
      cpha_r <= 1'b0;
      lsb_r <= 1'b0;
      sclk <= 1'b0;
      mosi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= state != IDLE || accept;
      div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + 1'b1;
      if (fire) begin
        sclk <= ~sclk;
        edge_cnt <= edge_cnt + 1'b1;
      end
      if (sample) rx_sr <= rx_in;
      if (shift_tx) begin
        mosi <= tx_bit;
        tx_sr <= tx_shift;
      end
      case (state)
        IDLE: begin
          sclk <= bus.cpol;
          mosi <= 1'b0;
          edge_cnt <= '0;
          if (accept) begin
            state <= SETUP;
            div_r <= bus.clk_div;
            cpha_r <= bus.cpha;
            lsb_r <= bus.lsb_first;
            ss_n <= ss_dec;
            mosi <= bus.cpha ? 1'b0 : bus.lsb_first ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
            tx_sr <= bus.cpha ? bus.tx_data : bus.lsb_first ? bus.tx_data >> 1 : bus.tx_data << 1;
          end
        end
        SETUP: if (tick) state <= XFER;
        XFER: if (tick && edge_cnt == LAST) state <= HOLD;
        HOLD: if (tick) begin
          state <= IDLE;
          ss_n <= '1;
          done <= 1'b1;
          rx_data <= rx_sr;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.MOSI = mosi;
  assign bus.SCLK = sclk;
  assign bus.SS_N = ss_n;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.rx_valid = done;
  assign bus.rx_data = rx_data;
endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: directed and random frames checked against a behavioural SPI slave and frame model
module tb_spi_master_cfg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  spi_master_cfg_if #(.DATA_W(8), .DIV_W(8), .NUM_SS(4), .SS_W(3)) bus ();
  spi_master_cfg #(.DATA_W(8), .DIV_W(8), .NUM_SS(4), .SS_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic sbit(input logic [7:0] w, input bit lsb, input int k);
    return lsb ? w[k] : w[7-k];
  endfunction
  task automatic run_frame(input logic [7:0] tx, input logic [7:0] sw, input logic [2:0] sel,
                           input bit pol, input bit pha, input bit lsb, input logic [7:0] dv,
                           input bit echo, input bit disturb, input int abort_at);
    int h, exp_done, cyc, edges, rises, nbits, idx;
    logic [7:0] mseq, exp_seq, exp_rx;
    logic [3:0] exp_ss;
    logic prev_sclk, prev_mosi;
    bit lead, ss_bad, stray;
    h = int'(dv) + 1;
    exp_done = 1 + (2 * 8 + 2) * h;
    exp_ss = 4'hF;
    if (sel < 3'd4) exp_ss[sel[1:0]] = 1'b0;
    for (int k = 0; k < 8; k++) exp_seq[k] = sbit(tx, lsb, k);
    exp_rx = echo ? tx : sw;
    edges = 0; rises = 0; nbits = 0; mseq = '0; ss_bad = 0; stray = 0;
    idx = pha ? -1 : 0;
    bus.tx_data = tx; bus.ss_sel = sel; bus.cpol = pol; bus.cpha = pha;
    bus.lsb_first = lsb; bus.clk_div = dv; bus.start = 1'b0;
    bus.MISO = pha ? 1'b0 : sbit(sw, lsb, 0);
    @(posedge clk); #1;
    chk("sclk_idle", bus.SCLK, pol);
    prev_sclk = bus.SCLK;
    prev_mosi = bus.MOSI;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    chk("ss_first", bus.SS_N, exp_ss);
    chk("busy_first", bus.busy, 1);
    while (bus.done !== 1'b1 && cyc < exp_done + 20 && cyc != abort_at) begin
      if (bus.SS_N !== exp_ss) ss_bad = 1;
      if (bus.SCLK !== prev_sclk) begin
        edges++;
        if (bus.SCLK === 1'b1) rises++;
        lead = bus.SCLK !== pol;
        if (lead != pha) begin
          if (nbits < 8) mseq[nbits] = prev_mosi;
          nbits++;
        end else idx++;
      end
      bus.MISO = echo ? bus.MOSI : (idx >= 0 && idx < 8) ? sbit(sw, lsb, idx) : 1'b0;
      prev_sclk = bus.SCLK;
      prev_mosi = bus.MOSI;
      if (disturb && cyc == 5) begin
        bus.start = 1'b1; bus.tx_data = ~tx; bus.clk_div = dv ^ 8'd3; bus.cpol = ~pol;
        bus.cpha = ~pha; bus.lsb_first = ~lsb; bus.ss_sel = sel ^ 3'd1;
      end
      if (disturb && cyc == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc == abort_at) begin
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_ss", bus.SS_N, 4'hF);
      chk("abort_sclk", bus.SCLK, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_rx", bus.rx_data, 0);
      chk("abort_done", bus.done, 0);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray = 1;
      end
      chk("abort_quiet", stray, 0);
      return;
    end
    chk("done_cycle", cyc, exp_done);
    chk("rx_data", bus.rx_data, exp_rx);
    chk("rx_valid", bus.rx_valid, 1);
    chk("busy_done", bus.busy, 1);
    chk("ss_release", bus.SS_N, 4'hF);
    chk("mosi_seq", mseq, exp_seq);
    chk("bit_count", nbits, 8);
    chk("sclk_edges", edges, 16);
    chk("sclk_rises", rises, 8);
    chk("ss_hold", ss_bad, 0);
    if (disturb) bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("done_pulse", bus.done, 0);
    chk("busy_after", bus.busy, 0);
    @(posedge clk); #1;
    chk("no_restart", {bus.busy, bus.SS_N}, 5'h0F);
  endtask
  initial begin
    bus.start = 1'b0; bus.tx_data = '0; bus.ss_sel = '0; bus.cpol = 1'b0; bus.cpha = 1'b0;
    bus.lsb_first = 1'b0; bus.clk_div = '0; bus.MISO = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss", bus.SS_N, 4'hF);
    chk("rst_sclk", bus.SCLK, 0);
    chk("rst_mosi", bus.MOSI, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", {bus.done, bus.rx_valid}, 0);
    chk("rst_rx", bus.rx_data, 0);
    rst = 1'b0;
    run_frame(8'hA5, 8'h00, 3'd0, 0, 0, 0, 8'd1, 1, 0, -1);
    run_frame(8'h3C, 8'h81, 3'd1, 1, 1, 1, 8'd2, 0, 0, -1);
    run_frame(8'($urandom), 8'($urandom), 3'd3, 0, 1, 0, 8'd0, 0, 0, -1);
    run_frame(8'($urandom), 8'($urandom), 3'd0, 1, 0, 1, 8'd0, 0, 0, -1);
    run_frame(8'($urandom), 8'($urandom), 3'd2, 0, 0, 0, 8'd1, 0, 0, -1);
    run_frame(8'($urandom), 8'($urandom), 3'd5, 1, 1, 0, 8'd1, 0, 0, -1);
    run_frame(8'($urandom), 8'($urandom) | 8'h01, 3'd1, 0, 0, 1, 8'd2, 0, 1, -1);
    run_frame(8'($urandom), 8'($urandom), 3'd2, 0, 0, 0, 8'd1, 0, 0, 10);
    run_frame(8'($urandom), 8'($urandom), 3'd2, 0, 0, 0, 8'd1, 0, 0, -1);
    run_frame(8'($urandom), 8'($urandom), 3'd3, 0, 1, 1, 8'd255, 0, 0, -1);
    for (int n = 0; n < 6; n++)
      run_frame(8'($urandom), 8'($urandom), 3'($urandom_range(0, 4)), 1'($urandom), 1'($urandom),
                1'($urandom), 8'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
